// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack CPU core and its ALU.
package hack_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 15;

  // Instruction bit positions
  localparam int I_TYPE = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int A_BIT  = 12;  // y operand select: 0 = A, 1 = M
  localparam int C_ZX   = 11;
  localparam int C_NX   = 10;
  localparam int C_ZY   = 9;
  localparam int C_NY   = 8;
  localparam int C_F    = 7;
  localparam int C_NO   = 6;
  localparam int D_A    = 5;
  localparam int D_D    = 4;
  localparam int D_M    = 3;
  localparam int J_LT   = 2;
  localparam int J_EQ   = 1;
  localparam int J_GT   = 0;

  // Two-phase instruction sequence to cover the registered ROM/RAM latency
  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: purely combinational, standard zx/nx/zy/ny/f/no semantics.
module hack_alu
  import hack_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         zx,
  input  logic         nx,
  input  logic         zy,
  input  logic         ny,
  input  logic         f,
  input  logic         no,
  output logic [W-1:0] out,
  output logic         zr,
  output logic         ng
);

  logic [W-1:0] x_z, x_n, y_z, y_n, res;

  // Operand conditioning, function select and output negation
  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    // Add wraps: carry out of the top bit is discarded
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
  end

  assign zr = (out == '0);
  assign ng = out[W-1];

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: A/D/PC registers, FETCH/EXEC sequencer and C-instruction decode.
// Memory timing: pc and address_m are registered and stable for the whole
// instruction, so the synchronous ROM/RAM return instruction and in_m during
// EXEC. RAM captures out_m when write_m is high at the edge ending EXEC.
module hack_cpu
  import hack_pkg::*;
#(
  parameter int WIDTH  = hack_pkg::WIDTH,
  parameter int ADDR_W = hack_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instruction,
  input  logic [WIDTH-1:0]  in_m,
  output logic [WIDTH-1:0]  out_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] address_m,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch
);

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  d_reg, d_next;
  logic [ADDR_W-1:0] pc_reg, pc_next, pc_inc;
  logic [WIDTH-1:0]  y_op, alu_out;
  logic              alu_zr, alu_ng;
  logic              is_c, jmp, write_en;
  logic              unused_bits;

  // Bits 14:13 of a C-instruction carry no meaning
  assign unused_bits = ^instruction[14:13];

  assign is_c   = instruction[I_TYPE];
  assign y_op   = instruction[A_BIT] ? in_m : a_reg;
  assign pc_inc = pc_reg + ADDR_W'(1);
  assign jmp    = (instruction[J_LT] & alu_ng)
                | (instruction[J_EQ] & alu_zr)
                | (instruction[J_GT] & ~alu_zr & ~alu_ng);

  hack_alu #(.W(WIDTH)) u_alu (
    .x   (d_reg),
    .y   (y_op),
    .zx  (instruction[C_ZX]),
    .nx  (instruction[C_NX]),
    .zy  (instruction[C_ZY]),
    .ny  (instruction[C_NY]),
    .f   (instruction[C_F]),
    .no  (instruction[C_NO]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next state, register next values and memory-side outputs
  always_comb begin
    state_next = state;
    a_next     = a_reg;
    d_next     = d_reg;
    pc_next    = pc_reg;
    out_m      = '0;
    write_en   = 1'b0;
    case (state)
      FETCH: begin
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        if (!is_c) begin
          a_next  = instruction;
          pc_next = pc_inc;
        end else begin
          out_m    = alu_out;
          write_en = instruction[D_M];
          if (instruction[D_A]) a_next = alu_out;
          if (instruction[D_D]) d_next = alu_out;
          // Jump target is the A value from before this instruction
          pc_next = jmp ? a_reg[ADDR_W-1:0] : pc_inc;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // A, D and PC registers; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else begin
      a_reg  <= a_next;
      d_reg  <= d_next;
      pc_reg <= pc_next;
    end
  end

  assign write_m   = write_en & ~reset;
  assign address_m = a_reg[ADDR_W-1:0];
  assign pc        = pc_reg;
  assign fetch     = (state == FETCH);

endmodule
